hamming74_decode_pipe: RTL and testbench

Two-stage pipelined Hamming(7,4) single-error-correcting decoder with valid/ready handshakes on both sides. It sits directly downstream of the error-injection stage and consumes its possibly-corrupted 7-bit codeword. It emits the corrected 4-bit data word, the syndrome and an error flag, and keeps saturating statistics counters for test visibility.

---
 rtl/hamming_pkg.sv | 27 ++
 rtl/ham74_correct.sv | 28 ++
 rtl/hamming74_decode_pipe.sv | 89 ++++++++
 tb/tb_hamming74_decode_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) shared constants and syndrome helper
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Parity bit k sits at position 2**k; data bits fill the remaining slots.
  localparam int PAR_POS  [SYN_W]  = '{1, 2, 4};
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7};

  // Syndrome bit k is the XOR of every position whose index has bit k set,
  // so a single flipped bit yields its own position number.
  function automatic logic [SYN_W-1:0] ham74_syndrome(input logic [1:CODE_W] code);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int k = 0; k < SYN_W; k++) begin
      for (int j = 1; j <= CODE_W; j++) begin
        if ((j & PAR_POS[k]) != 0) begin
          syn[k] = syn[k] ^ code[j];
        end
      end
    end
    return syn;
  endfunction

endpackage

// File: rtl/ham74_correct.sv
// rtl/ham74_correct.sv - combinational single-bit correction and data extraction
module ham74_correct
  import hamming_pkg::*;
(
  input  logic [1:CODE_W]    code,
  input  logic [SYN_W-1:0]   syndrome,
  output logic [1:DATA_W]    data,
  output logic               err
);

  logic [1:CODE_W] fixed;

  // Flip the bit the syndrome points at, then pick the data positions out.
  always_comb begin
    fixed = code;
    data  = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (syndrome == SYN_W'(i)) begin
        fixed[i] = ~code[i];
      end
    end
    for (int k = 0; k < DATA_W; k++) begin
      data[k+1] = fixed[DATA_POS[k]];
    end
    err = (syndrome != '0);
  end

endmodule

// File: rtl/hamming74_decode_pipe.sv
// rtl/hamming74_decode_pipe.sv - two-stage Hamming(7,4) decoder with stats counters
module hamming74_decode_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:CODE_W]    in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:DATA_W]    out_data,
  output logic [SYN_W-1:0]   out_syndrome,
  output logic               out_err,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   words_cnt,
  output logic [CNT_W-1:0]   corr_cnt
);

  logic                s1_valid;
  logic [1:CODE_W]     s1_code;
  logic [SYN_W-1:0]    s1_syn;
  logic                s2_load;
  logic [1:DATA_W]     fix_data;
  logic                fix_err;
  logic                out_fire;

  // A register may load when empty or when its occupant leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_fire = out_valid && out_ready;

  ham74_correct u_correct (
    .code     (s1_code),
    .syndrome (s1_syn),
    .data     (fix_data),
    .err      (fix_err)
  );

  // Stage 1: capture the codeword together with its syndrome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= ham74_syndrome(in_code);
      end
    end
  end

  // Stage 2: register corrected data; fields hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= fix_data;
        out_syndrome <= s1_syn;
        out_err      <= fix_err;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      words_cnt <= '0;
      corr_cnt  <= '0;
    end else if (out_fire) begin
      if (words_cnt != {CNT_W{1'b1}}) begin
        words_cnt <= words_cnt + CNT_W'(1);
      end
      if (out_err && (corr_cnt != {CNT_W{1'b1}})) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming74_decode_pipe.sv
// tb/tb_hamming74_decode_pipe.sv - directed self-checking bench for hamming74_decode_pipe
module tb_hamming74_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, stat_clr;
  logic        in_ready, out_valid, out_err;
  logic [1:7]  in_code;
  logic [1:4]  out_data;
  logic [2:0]  out_syndrome;
  logic [15:0] words_cnt, corr_cnt;

  logic        s_in_valid, s_out_ready, s_stat_clr;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [1:7]  s_in_code;
  logic [1:4]  s_out_data;
  logic [2:0]  s_out_syndrome;
  logic [1:0]  s_words_cnt, s_corr_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hamming74_decode_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_err(out_err),
    .stat_clr(stat_clr), .words_cnt(words_cnt), .corr_cnt(corr_cnt)
  );

  hamming74_decode_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_code(s_in_code), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_syndrome(s_out_syndrome), .out_err(s_out_err),
    .stat_clr(s_stat_clr), .words_cnt(s_words_cnt), .corr_cnt(s_corr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:7] base;
    logic [1:7] c;
    logic [1:7] bp_code [5];
    logic [1:4] bp_data [5];
    int         acc;
    int         rcv;

    base = 7'b0110011;
    bp_code = '{7'b0110011, 7'b0000000, 7'b1111111, 7'b0110111, 7'b1111110};
    bp_data = '{4'b1011, 4'b0000, 4'b1111, 4'b1011, 4'b1111};

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; stat_clr = 1'b0;
    s_in_valid = 1'b0; s_in_code = '0; s_out_ready = 1'b1; s_stat_clr = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_words_cnt", 32'(words_cnt), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Clean word
    in_valid = 1'b1; in_code = 7'b0110011;
    step();
    in_valid = 1'b0;
    chk("clean_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    chk("clean_out_valid", 32'(out_valid), 32'd1);
    chk("clean_out_data", 32'(out_data), 32'hb);
    chk("clean_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("clean_out_err", 32'(out_err), 32'd0);
    step();
    chk("clean_words_cnt", 32'(words_cnt), 32'd1);
    chk("clean_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("clean_drained", 32'(out_valid), 32'd0);

    // Single error at data position 5
    in_valid = 1'b1; in_code = 7'b0110111;
    step();
    in_valid = 1'b0;
    step();
    chk("e5_out_valid", 32'(out_valid), 32'd1);
    chk("e5_out_syndrome", 32'(out_syndrome), 32'd5);
    chk("e5_out_data", 32'(out_data), 32'hb);
    chk("e5_out_err", 32'(out_err), 32'd1);
    step();
    chk("e5_corr_cnt", 32'(corr_cnt), 32'd1);
    chk("e5_words_cnt", 32'(words_cnt), 32'd2);

    // Clear counters, then sweep single errors over positions 1..7 back to back
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_words_cnt", 32'(words_cnt), 32'd0);
    chk("clr_corr_cnt", 32'(corr_cnt), 32'd0);
    rcv = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        chk("sweep_syndrome", 32'(out_syndrome), 32'(rcv + 1));
        chk("sweep_data", 32'(out_data), 32'hb);
        chk("sweep_err", 32'(out_err), 32'd1);
        rcv++;
      end
      if (cyc < 7) begin
        c = base;
        c[cyc+1] = ~c[cyc+1];
        in_valid = 1'b1; in_code = c;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("sweep_received", 32'(rcv), 32'd7);
    chk("sweep_words_cnt", 32'(words_cnt), 32'd7);
    chk("sweep_corr_cnt", 32'(corr_cnt), 32'd7);

    // Back-pressure: offer 5 words with the output stalled
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = bp_code[i];
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'(bp_data[0]));
    chk("bp_words_stalled", 32'(words_cnt), 32'd7);
    out_ready = 1'b1;
    rcv = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (out_valid) begin
        if (rcv < 2) chk("bp_order_data", 32'(out_data), 32'(bp_data[rcv]));
        rcv++;
      end
      step();
    end
    chk("bp_received", 32'(rcv), 32'd2);
    chk("bp_words_cnt", 32'(words_cnt), 32'd9);

    // Reset with two words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_code = bp_code[3];
      step();
    end
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_words_cnt", 32'(words_cnt), 32'd0);
    chk("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 7'b1111110;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'hf);
    chk("post_rst_syndrome", 32'(out_syndrome), 32'd7);
    step();
    chk("post_rst_words_cnt", 32'(words_cnt), 32'd1);

    // Saturation on the 2-bit counter instance
    for (int cyc = 0; cyc < 9; cyc++) begin
      s_in_valid = (cyc < 5);
      s_in_code  = 7'b0110111;
      step();
    end
    s_in_valid = 1'b0;
    chk("sat_words_cnt", 32'(s_words_cnt), 32'd3);
    chk("sat_corr_cnt", 32'(s_corr_cnt), 32'd3);
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step();
    chk("sat_clr_pending_valid", 32'(s_out_valid), 32'd1);
    s_stat_clr = 1'b1;
    step();
    s_stat_clr = 1'b0;
    chk("sat_clr_words_cnt", 32'(s_words_cnt), 32'd0);
    chk("sat_clr_corr_cnt", 32'(s_corr_cnt), 32'd0);
    chk("sat_clr_drained", 32'(s_out_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
